// File: rtl/decode_pipe_if.sv
// Decode-stage bus: IF/ID inputs, IF feedback, register-file ports and the registered ID/EX bundle.
interface decode_pipe_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
);
  logic              fw_if_id_stall;
  logic              ex_id_flush;
  logic              if_id_valid;
  logic [DATA_W-1:0] if_id_instrucao;
  logic [DATA_W-1:0] if_id_proximopc;
  logic              id_if_stall;
  logic              id_if_selfontepc;
  logic [DATA_W-1:0] id_if_pcimd2ext;
  logic [DATA_W-1:0] id_if_pcindex;
  logic [RA_W-1:0]   id_reg_addra;
  logic [RA_W-1:0]   id_reg_addrb;
  logic [DATA_W-1:0] reg_id_dataa;
  logic [DATA_W-1:0] reg_id_datab;
  logic              id_ex_valid;
  logic [2:0]        id_ex_aluop;
  logic              id_ex_selimregb;
  logic [1:0]        id_ex_shiftop;
  logic [4:0]        id_ex_shiftamt;
  logic [DATA_W-1:0] id_ex_rega;
  logic [DATA_W-1:0] id_ex_regb;
  logic [DATA_W-1:0] id_ex_imedext;
  logic [DATA_W-1:0] id_ex_proximopc;
  logic              id_ex_readmem;
  logic              id_ex_writemem;
  logic [RA_W-1:0]   id_ex_regdest;
  logic              id_ex_writereg;

  modport slave (
    input  fw_if_id_stall, ex_id_flush, if_id_valid, if_id_instrucao, if_id_proximopc,
    input  reg_id_dataa, reg_id_datab,
    output id_if_stall, id_if_selfontepc, id_if_pcimd2ext, id_if_pcindex,
    output id_reg_addra, id_reg_addrb,
    output id_ex_valid, id_ex_aluop, id_ex_selimregb, id_ex_shiftop, id_ex_shiftamt,
    output id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_proximopc,
    output id_ex_readmem, id_ex_writemem, id_ex_regdest, id_ex_writereg
  );

  modport master (
    output fw_if_id_stall, ex_id_flush, if_id_valid, if_id_instrucao, if_id_proximopc,
    output reg_id_dataa, reg_id_datab,
    input  id_if_stall, id_if_selfontepc, id_if_pcimd2ext, id_if_pcindex,
    input  id_reg_addra, id_reg_addrb,
    input  id_ex_valid, id_ex_aluop, id_ex_selimregb, id_ex_shiftop, id_ex_shiftamt,
    input  id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_proximopc,
    input  id_ex_readmem, id_ex_writemem, id_ex_regdest, id_ex_writereg
  );
endinterface

// File: rtl/decode_pipe.sv
// MIPS decode stage: comb branch/jump resolution and regfile addressing, 1-cycle registered ID/EX bundle.
// Stall holds ID/EX; flush, load-use hazard or an empty IF/ID slot load an all-zero bubble.
module decode_pipe #(
  parameter int DATA_W   = 32,
  parameter int RA_W     = 5,
  parameter int LINK_REG = 31,
  parameter int IMM_W    = 16
) (
  input  logic          clock,
  input  logic          reset,
  decode_pipe_if.slave  bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_ADD = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [4:0] RI_BLTZ = 5'h00, RI_BGEZ = 5'h01, RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SHF = 3'd4;

  typedef struct packed {
    logic              valid;
    logic [2:0]        aluop;
    logic              selimregb;
    logic [1:0]        shiftop;
    logic [4:0]        shiftamt;
    logic [DATA_W-1:0] rega;
    logic [DATA_W-1:0] regb;
    logic [DATA_W-1:0] imedext;
    logic [DATA_W-1:0] proximopc;
    logic              readmem;
    logic              writemem;
    logic [RA_W-1:0]   regdest;
    logic              writereg;
  } idex_t;

  idex_t             r_idex;
  idex_t             w_dec;
  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [4:0]        w_ri_sel;
  logic [RA_W-1:0]   w_rs;
  logic [RA_W-1:0]   w_rt;
  logic [RA_W-1:0]   w_rd;
  logic [RA_W-1:0]   w_addrb;
  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-1:0] w_imedext;
  logic              w_a_neg;
  logic              w_a_zero;
  logic              w_a_eq_b;
  logic              w_b_used;
  logic              w_taken;
  logic              w_hazard;

  assign w_op      = bus.if_id_instrucao[31:26];
  assign w_funct   = bus.if_id_instrucao[5:0];
  assign w_ri_sel  = bus.if_id_instrucao[20:16];
  assign w_rs      = bus.if_id_instrucao[21 +: RA_W];
  assign w_rt      = bus.if_id_instrucao[16 +: RA_W];
  assign w_rd      = bus.if_id_instrucao[11 +: RA_W];
  assign w_imm     = bus.if_id_instrucao[IMM_W-1:0];
  assign w_imedext = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_a_neg   = bus.reg_id_dataa[DATA_W-1];
  assign w_a_zero  = (bus.reg_id_dataa == '0);
  assign w_a_eq_b  = (bus.reg_id_dataa == bus.reg_id_datab);

  always_comb begin
    w_dec           = '0;
    w_dec.valid     = 1'b1;
    w_dec.shiftamt  = bus.if_id_instrucao[10:6];
    w_dec.rega      = bus.reg_id_dataa;
    w_dec.regb      = bus.reg_id_datab;
    w_dec.imedext   = w_imedext;
    w_dec.proximopc = bus.if_id_proximopc;
    w_addrb         = w_rt;
    w_b_used        = 1'b0;
    w_taken         = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_b_used       = 1'b1;
        w_dec.regdest  = w_rd;
        w_dec.writereg = 1'b1;
        case (w_funct)
          FN_ADD, FN_ADDU: w_dec.aluop = ALU_ADD;
          FN_SUB:          w_dec.aluop = ALU_SUB;
          FN_AND:          w_dec.aluop = ALU_AND;
          FN_OR:           w_dec.aluop = ALU_OR;
          FN_SLL: begin w_dec.aluop = ALU_SHF; w_dec.shiftop = 2'b00; end
          FN_SRL: begin w_dec.aluop = ALU_SHF; w_dec.shiftop = 2'b01; end
          FN_SRA: begin w_dec.aluop = ALU_SHF; w_dec.shiftop = 2'b11; end
          default: begin w_dec.regdest = '0; w_dec.writereg = 1'b0; end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin
        w_dec.selimregb = 1'b1;
        w_dec.regdest   = w_rt;
        w_dec.writereg  = 1'b1;
        w_dec.readmem   = (w_op == OP_LW);
      end
      OP_SW: begin
        w_b_used        = 1'b1;
        w_dec.selimregb = 1'b1;
        w_dec.writemem  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_b_used    = 1'b1;
        w_dec.aluop = ALU_SUB;
        w_taken     = (w_op == OP_BEQ) ? w_a_eq_b : !w_a_eq_b;
      end
      OP_BLEZ: begin w_addrb = '0; w_taken = w_a_neg || w_a_zero; end
      OP_BGTZ: begin w_addrb = '0; w_taken = !w_a_neg && !w_a_zero; end
      OP_REGIMM: begin
        w_addrb = '0;
        case (w_ri_sel)
          RI_BLTZ, RI_BLTZAL: w_taken = w_a_neg;
          RI_BGEZ, RI_BGEZAL: w_taken = !w_a_neg;
          default:            w_taken = 1'b0;
        endcase
        // Links write r31 regardless of the branch outcome
        if (w_ri_sel == RI_BLTZAL || w_ri_sel == RI_BGEZAL) begin
          w_dec.regdest  = RA_W'(LINK_REG);
          w_dec.writereg = 1'b1;
        end
      end
      OP_J: w_taken = 1'b1;
      OP_JAL: begin
        w_taken        = 1'b1;
        w_dec.regdest  = RA_W'(LINK_REG);
        w_dec.writereg = 1'b1;
      end
      default: w_taken = 1'b0;
    endcase
  end

  assign w_hazard = r_idex.valid && r_idex.readmem && (r_idex.regdest != '0) && bus.if_id_valid &&
                    ((r_idex.regdest == w_rs) || (w_b_used && (r_idex.regdest == w_addrb)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idex <= '0;
    end else if (bus.ex_id_flush) begin
      r_idex <= '0;
    end else if (!bus.fw_if_id_stall) begin
      r_idex <= (w_hazard || !bus.if_id_valid) ? '0 : w_dec;
    end
  end

  assign bus.id_if_stall      = w_hazard && !bus.ex_id_flush;
  assign bus.id_if_selfontepc = w_taken && bus.if_id_valid && !w_hazard && !bus.ex_id_flush;
  assign bus.id_if_pcimd2ext  = bus.if_id_proximopc + (w_imedext << 2);
  assign bus.id_if_pcindex    = {bus.if_id_proximopc[DATA_W-1:28], bus.if_id_instrucao[25:0], 2'b00};
  assign bus.id_reg_addra     = w_rs;
  assign bus.id_reg_addrb     = w_addrb;

  assign bus.id_ex_valid      = r_idex.valid;
  assign bus.id_ex_aluop      = r_idex.aluop;
  assign bus.id_ex_selimregb  = r_idex.selimregb;
  assign bus.id_ex_shiftop    = r_idex.shiftop;
  assign bus.id_ex_shiftamt   = r_idex.shiftamt;
  assign bus.id_ex_rega       = r_idex.rega;
  assign bus.id_ex_regb       = r_idex.regb;
  assign bus.id_ex_imedext    = r_idex.imedext;
  assign bus.id_ex_proximopc  = r_idex.proximopc;
  assign bus.id_ex_readmem    = r_idex.readmem;
  assign bus.id_ex_writemem   = r_idex.writemem;
  assign bus.id_ex_regdest    = r_idex.regdest;
  assign bus.id_ex_writereg   = r_idex.writereg;
endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: expected ID/EX bundles queued at drive time, popped one edge later.
module tb_decode_pipe;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  decode_pipe_if #(.DATA_W(32), .RA_W(5)) bus ();
  decode_pipe #(.DATA_W(32), .RA_W(5), .LINK_REG(31), .IMM_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic [2:0]  aluop;
    logic        selimm;
    logic [1:0]  shop;
    logic [4:0]  shamt;
    logic [31:0] rega, regb, imm, pc;
    logic        rdm, wrm;
    logic [4:0]  rdest;
    logic        wreg;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '{valid: 1'b0, aluop: 3'd0, selimm: 1'b0, shop: 2'd0, shamt: 5'd0, rega: 32'd0, regb: 32'd0,
          imm: 32'd0, pc: 32'd0, rdm: 1'b0, wrm: 1'b0, rdest: 5'd0, wreg: 1'b0};
    return e;
  endfunction

  function automatic exp_t mk(input logic [2:0] aluop, input logic selimm, input logic [1:0] shop,
                              input logic [31:0] ins, pc, a, b, input logic rdm, wrm,
                              input logic [4:0] rdest, input logic wreg);
    exp_t e;
    e = '{valid: 1'b1, aluop: aluop, selimm: selimm, shop: shop, shamt: ins[10:6], rega: a, regb: b,
          imm: {{16{ins[15]}}, ins[15:0]}, pc: pc, rdm: rdm, wrm: wrm, rdest: rdest, wreg: wreg};
    return e;
  endfunction

  task automatic drive(input logic [31:0] ins, pc, a, b, input logic v = 1'b1, fl = 1'b0,
                       st = 1'b0, rst = 1'b0);
    @(negedge clock);
    reset               = rst;
    bus.if_id_instrucao = ins;
    bus.if_id_proximopc = pc;
    bus.reg_id_dataa    = a;
    bus.reg_id_datab    = b;
    bus.if_id_valid     = v;
    bus.ex_id_flush     = fl;
    bus.fw_if_id_stall  = st;
    #1;
  endtask

  task automatic cmb(input string tag, input logic sel, input logic stall);
    check({tag, ".selfontepc"}, bus.id_if_selfontepc, sel);
    check({tag, ".id_if_stall"}, bus.id_if_stall, stall);
  endtask

  task automatic step(input string tag, input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      x = sb.pop_front();
      check({tag, ".valid"},     bus.id_ex_valid,     x.valid);
      check({tag, ".aluop"},     bus.id_ex_aluop,     x.aluop);
      check({tag, ".selimregb"}, bus.id_ex_selimregb, x.selimm);
      check({tag, ".shiftop"},   bus.id_ex_shiftop,   x.shop);
      check({tag, ".shiftamt"},  bus.id_ex_shiftamt,  x.shamt);
      check({tag, ".rega"},      bus.id_ex_rega,      x.rega);
      check({tag, ".regb"},      bus.id_ex_regb,      x.regb);
      check({tag, ".imedext"},   bus.id_ex_imedext,   x.imm);
      check({tag, ".proximopc"}, bus.id_ex_proximopc, x.pc);
      check({tag, ".readmem"},   bus.id_ex_readmem,   x.rdm);
      check({tag, ".writemem"},  bus.id_ex_writemem,  x.wrm);
      check({tag, ".regdest"},   bus.id_ex_regdest,   x.rdest);
      check({tag, ".writereg"},  bus.id_ex_writereg,  x.wreg);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;

    // Reset with a live ADDI presented
    ins = itype(6'h08, 5'd3, 5'd21, 16'hFFFF);
    drive(ins, 32'd666, 32'd7, 32'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    step("reset", bubble());

    drive(ins, 32'd666, 32'd7, 32'd9);
    cmb("addi", 1'b0, 1'b0);
    check("addi.addra", bus.id_reg_addra, 5'd3);
    check("addi.addrb", bus.id_reg_addrb, 5'd21);
    step("addi", mk(3'd0, 1'b1, 2'b00, ins, 32'd666, 32'd7, 32'd9, 1'b0, 1'b0, 5'd21, 1'b1));

    ins = itype(6'h01, 5'd4, 5'h10, 16'hFFED);
    drive(ins, 32'd0, 32'hFFFF_FFFB, 32'h55);
    cmb("bltzal", 1'b1, 1'b0);
    check("bltzal.pcimd2ext", bus.id_if_pcimd2ext, 32'hFFFF_FFB4);
    check("bltzal.addrb", bus.id_reg_addrb, 5'd0);
    step("bltzal", mk(3'd0, 1'b0, 2'b00, ins, 32'd0, 32'hFFFF_FFFB, 32'h55, 1'b0, 1'b0, 5'd31, 1'b1));

    ins = itype(6'h01, 5'd4, 5'h11, 16'h0010);
    drive(ins, 32'h100, 32'hFFFF_FFFB, 32'h0);
    cmb("bgezal_nt", 1'b0, 1'b0);
    step("bgezal_nt", mk(3'd0, 1'b0, 2'b00, ins, 32'h100, 32'hFFFF_FFFB, 32'h0, 1'b0, 1'b0, 5'd31, 1'b1));

    // Load-use through rs
    ins = itype(6'h23, 5'd2, 5'd8, 16'd4);
    drive(ins, 32'h200, 32'h1000, 32'h0);
    cmb("lw8", 1'b0, 1'b0);
    step("lw8", mk(3'd0, 1'b1, 2'b00, ins, 32'h200, 32'h1000, 32'h0, 1'b1, 1'b0, 5'd8, 1'b1));
    ins = rtype(5'd8, 5'd9, 5'd10, 5'd0, 6'h20);
    drive(ins, 32'h204, 32'd1, 32'd2);
    cmb("add_haz", 1'b0, 1'b1);
    step("add_haz", bubble());
    drive(ins, 32'h204, 32'd1, 32'd2);
    cmb("add_go", 1'b0, 1'b0);
    step("add_go", mk(3'd0, 1'b0, 2'b00, ins, 32'h204, 32'd1, 32'd2, 1'b0, 1'b0, 5'd10, 1'b1));

    // Load-use through a used rt (store data)
    ins = itype(6'h23, 5'd1, 5'd5, 16'd8);
    drive(ins, 32'h300, 32'h40, 32'h0);
    step("lw5", mk(3'd0, 1'b1, 2'b00, ins, 32'h300, 32'h40, 32'h0, 1'b1, 1'b0, 5'd5, 1'b1));
    ins = itype(6'h2B, 5'd0, 5'd5, 16'd12);
    drive(ins, 32'h304, 32'h0, 32'hAB);
    cmb("sw_haz", 1'b0, 1'b1);
    step("sw_haz", bubble());
    drive(ins, 32'h304, 32'h0, 32'hAB);
    cmb("sw_go", 1'b0, 1'b0);
    step("sw_go", mk(3'd0, 1'b1, 2'b00, ins, 32'h304, 32'h0, 32'hAB, 1'b0, 1'b1, 5'd0, 1'b0));

    // rt of an I-type is a destination, not a source: no hazard
    ins = itype(6'h23, 5'd1, 5'd6, 16'd0);
    drive(ins, 32'h400, 32'h10, 32'h0);
    step("lw6", mk(3'd0, 1'b1, 2'b00, ins, 32'h400, 32'h10, 32'h0, 1'b1, 1'b0, 5'd6, 1'b1));
    ins = itype(6'h09, 5'd1, 5'd6, 16'd2);
    drive(ins, 32'h404, 32'h10, 32'h0);
    cmb("addiu_nohaz", 1'b0, 1'b0);
    step("addiu_nohaz", mk(3'd0, 1'b1, 2'b00, ins, 32'h404, 32'h10, 32'h0, 1'b0, 1'b0, 5'd6, 1'b1));

    // Load into r0 never stalls
    ins = itype(6'h23, 5'd1, 5'd0, 16'd0);
    drive(ins, 32'h500, 32'h10, 32'h0);
    step("lw0", mk(3'd0, 1'b1, 2'b00, ins, 32'h500, 32'h10, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1));
    ins = rtype(5'd0, 5'd0, 5'd7, 5'd0, 6'h20);
    drive(ins, 32'h504, 32'h0, 32'h0);
    cmb("add_r0", 1'b0, 1'b0);
    step("add_r0", mk(3'd0, 1'b0, 2'b00, ins, 32'h504, 32'h0, 32'h0, 1'b0, 1'b0, 5'd7, 1'b1));

    // External stall holds SLL for three cycles
    ins = rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'h00);
    drive(ins, 32'h600, 32'h0, 32'h3);
    step("sll", mk(3'd4, 1'b0, 2'b00, ins, 32'h600, 32'h0, 32'h3, 1'b0, 1'b0, 5'd3, 1'b1));
    for (int i = 0; i < 3; i++) begin
      drive(itype(6'h08, 5'd1, 5'd2, 16'd9), 32'h604, 32'h77, 32'h88, 1'b1, 1'b0, 1'b1);
      step($sformatf("fwstall%0d", i), mk(3'd4, 1'b0, 2'b00, ins, 32'h600, 32'h0, 32'h3, 1'b0, 1'b0, 5'd3, 1'b1));
    end

    ins = rtype(5'd0, 5'd2, 5'd4, 5'd7, 6'h03);
    drive(ins, 32'h608, 32'h0, 32'h80000000);
    step("sra", mk(3'd4, 1'b0, 2'b11, ins, 32'h608, 32'h0, 32'h80000000, 1'b0, 1'b0, 5'd4, 1'b1));
    ins = rtype(5'd5, 5'd6, 5'd7, 5'd0, 6'h22);
    drive(ins, 32'h60C, 32'd9, 32'd4);
    step("sub", mk(3'd1, 1'b0, 2'b00, ins, 32'h60C, 32'd9, 32'd4, 1'b0, 1'b0, 5'd7, 1'b1));
    ins = rtype(5'd5, 5'd6, 5'd8, 5'd0, 6'h25);
    drive(ins, 32'h610, 32'd9, 32'd4);
    step("or", mk(3'd3, 1'b0, 2'b00, ins, 32'h610, 32'd9, 32'd4, 1'b0, 1'b0, 5'd8, 1'b1));

    // Branches
    ins = itype(6'h04, 5'd1, 5'd2, 16'h0003);
    drive(ins, 32'h1000, 32'd5, 32'd5);
    cmb("beq", 1'b1, 1'b0);
    check("beq.pcimd2ext", bus.id_if_pcimd2ext, 32'h100C);
    step("beq", mk(3'd1, 1'b0, 2'b00, ins, 32'h1000, 32'd5, 32'd5, 1'b0, 1'b0, 5'd0, 1'b0));
    drive(ins, 32'h1000, 32'd5, 32'd5, 1'b1, 1'b1);
    cmb("beq_flush", 1'b0, 1'b0);
    step("beq_flush", bubble());
    ins = itype(6'h05, 5'd1, 5'd2, 16'h0003);
    drive(ins, 32'h1004, 32'd5, 32'd5);
    cmb("bne_nt", 1'b0, 1'b0);
    step("bne_nt", mk(3'd1, 1'b0, 2'b00, ins, 32'h1004, 32'd5, 32'd5, 1'b0, 1'b0, 5'd0, 1'b0));
    ins = itype(6'h06, 5'd3, 5'd7, 16'h0001);
    drive(ins, 32'h1008, 32'd0, 32'd1);
    cmb("blez0", 1'b1, 1'b0);
    check("blez0.addrb", bus.id_reg_addrb, 5'd0);
    step("blez0", mk(3'd0, 1'b0, 2'b00, ins, 32'h1008, 32'd0, 32'd1, 1'b0, 1'b0, 5'd0, 1'b0));
    ins = itype(6'h07, 5'd3, 5'd7, 16'h0001);
    drive(ins, 32'h100C, 32'h80000000, 32'd1);
    cmb("bgtz_neg", 1'b0, 1'b0);
    check("bgtz_neg.addrb", bus.id_reg_addrb, 5'd0);
    step("bgtz_neg", mk(3'd0, 1'b0, 2'b00, ins, 32'h100C, 32'h80000000, 32'd1, 1'b0, 1'b0, 5'd0, 1'b0));

    // Jumps
    ins = {6'h02, 26'h0000123};
    drive(ins, 32'h3000_0004, 32'd0, 32'd0);
    cmb("j", 1'b1, 1'b0);
    check("j.pcindex", bus.id_if_pcindex, 32'h3000_048C);
    step("j", mk(3'd0, 1'b0, 2'b00, ins, 32'h3000_0004, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0));
    ins = {6'h03, 26'h0000040};
    drive(ins, 32'h0000_0010, 32'd0, 32'd0);
    cmb("jal", 1'b1, 1'b0);
    check("jal.pcindex", bus.id_if_pcindex, 32'h0000_0100);
    step("jal", mk(3'd0, 1'b0, 2'b00, ins, 32'h10, 32'd0, 32'd0, 1'b0, 1'b0, 5'd31, 1'b1));

    // Unknown opcode is a live NOP
    ins = itype(6'h3F, 5'd1, 5'd2, 16'h1234);
    drive(ins, 32'h2000, 32'd3, 32'd4);
    cmb("unk", 1'b0, 1'b0);
    step("unk", mk(3'd0, 1'b0, 2'b00, ins, 32'h2000, 32'd3, 32'd4, 1'b0, 1'b0, 5'd0, 1'b0));

    // Empty IF/ID slot
    drive({6'h02, 26'h0000123}, 32'h4, 32'd0, 32'd0, 1'b0);
    cmb("invalid_j", 1'b0, 1'b0);
    step("invalid_j", bubble());
    ins = itype(6'h23, 5'd2, 5'd8, 16'd4);
    drive(ins, 32'h700, 32'h0, 32'h0);
    step("lw8b", mk(3'd0, 1'b1, 2'b00, ins, 32'h700, 32'h0, 32'h0, 1'b1, 1'b0, 5'd8, 1'b1));
    drive(rtype(5'd8, 5'd9, 5'd10, 5'd0, 6'h20), 32'h704, 32'd1, 32'd2, 1'b0);
    cmb("invalid_add", 1'b0, 1'b0);
    step("invalid_add", bubble());

    // Reset overrides stall
    ins = itype(6'h08, 5'd3, 5'd21, 16'h0005);
    drive(ins, 32'h800, 32'd7, 32'd9);
    step("addi2", mk(3'd0, 1'b1, 2'b00, ins, 32'h800, 32'd7, 32'd9, 1'b0, 1'b0, 5'd21, 1'b1));
    drive(ins, 32'h800, 32'd7, 32'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    step("reset_stall", bubble());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
